spi_flash_word_reader: RTL
==========================

// Module: spi_flash_word_reader
//
// PURPOSE
//   Memory-side responder that services 32-bit word read strobes from the core
//   by running a standard SPI flash READ (0x03) transaction.
//   - Shifts out command and 24-bit address, then shifts in 4 data bytes.
//   - Holds rbusy high while the transfer is in progress.
//   - Presents the word on rdata when rbusy drops.
//   Read-only: it has no write path. It sits in the SoC address decoder on the
//   flash window, next to the BRAM and IO responders.
//
// PARAMETERS
//   CLK_DIV   1   SPI half-period in clk cycles (>=1); one SPI bit = 2*CLK_DIV clks
//   ADDR_W    24  width of the byte address forwarded to the flash
//
// PORTS
//   clk        in   1       system clock; all logic on posedge
//   resetn     in   1       synchronous reset, active low
//   rstrb      in   1       read strobe, one-cycle pulse from core
//   addr       in   ADDR_W  byte address; addr[1:0] ignored (word aligned)
//   rdata      out  32      read word, valid while rbusy==0 after a read
//   rbusy      out  1       high while a read is in flight
//   spi_cs_n   out  1       flash chip select, active low
//   spi_clk    out  1       SPI clock, mode 0 (idle low)
//   spi_mosi   out  1       serial data to flash
//   spi_miso   in   1       serial data from flash
//
// BEHAVIOUR
//   Reset (resetn==0 at posedge), all registered:
//     - rbusy=0, spi_cs_n=1, spi_clk=0, spi_mosi=0, rdata=0.
//     - state=IDLE, all counters cleared.
//     - Reset mid-transfer aborts the transfer at that edge. No partial rdata update.
//   States: IDLE -> SHIFT -> IDLE.
//   IDLE:
//     - When rstrb==1, load the 64-bit shifter with {8'h03, addr[23:2], 2'b00, 32'h0}.
//     - At the same edge: spi_cs_n<=0, rbusy<=1, spi_mosi<=bit 63 (0), spi_clk<=0.
//       The bit counter is cleared and the state becomes SHIFT.
//     - Because rbusy is registered, it is already 1 in the cycle after rstrb.
//       The core samples rbusy in that cycle.
//   SHIFT (div counter 0..CLK_DIV-1 per half-period):
//     - Low phase: CLK_DIV clks with spi_clk=0. At its end, spi_clk<=1.
//     - High phase: CLK_DIV clks with spi_clk=1.
//       - At its end: spi_clk<=0, sample spi_miso into the shifter LSB, shift left,
//         drive spi_mosi with the next bit, increment bit counter (6 bits).
//       - MISO is sampled using the value present on the last high-phase clk,
//         i.e. after the rising edge and before the falling edge.
//     - After the 64th bit's high phase:
//       - spi_cs_n<=1, spi_clk<=0, spi_mosi<=0, rbusy<=0, state IDLE.
//       - rdata<=byte-swapped received word:
//         - first received byte -> rdata[7:0]
//         - 2nd byte -> [15:8]
//         - 3rd byte -> [23:16]
//         - 4th byte -> [31:24]
//         - Each byte arrives MSB first, so rdata matches little-endian memory order.
//   Latency: rbusy is high for exactly 128*CLK_DIV clk cycles.
//   - rstrb while rbusy==1 is ignored. There is no queueing.
//   - rstrb in the cycle rbusy==0 again is accepted. spi_cs_n is then high for
//     exactly 1 clk between transfers.
//   - rdata holds its value until the end of the next completed transfer.
//   - spi_clk never toggles while spi_cs_n==1.
//   - The MOSI data phase (last 32 bits) is 0.
//
// TESTING (bench with behavioural SPI flash model, mode 0)
//   1. Hold resetn=0 2 clks.
//      -> rbusy=0, spi_cs_n=1, spi_clk=0, spi_mosi=0, rdata=0.
//   2. CLK_DIV=1, flash[0x104..0x107]=13 05 00 00, pulse rstrb with addr=0x000104.
//      -> MOSI bytes 03 00 01 04.
//      -> rbusy high 128 clks, then rdata=0x00000513.
//   3. CLK_DIV=3, same read.
//      -> spi_clk high/low 3 clks each, rbusy high 384 clks, same rdata.
//   4. addr=0x0000FF with flash[0xFC..0xFF]=AA BB CC DD.
//      -> address bytes sent 00 00 FC; rdata=0xDDCCBBAA.
//   5. Pulse rstrb again mid-transfer.
//      -> ignored, single 64-bit transaction.
//      -> rstrb on first clk rbusy==0 gives cs_n high exactly 1 clk, then new read correct.
//   6. resetn=0 during data phase (bit 40).
//      -> next edge spi_cs_n=1, rbusy=0, rdata=0.
//      -> following read returns correct word.

Source files
------------

// File: rtl/spi_flash_word_reader_if.sv
// Core-side read bus for the SPI flash word reader.
//   rstrb  : one-cycle read strobe from the core
//   addr   : byte address (low two bits ignored by the responder)
//   rdata  : returned 32-bit word, valid while rbusy==0 after a read
//   rbusy  : high while a read is in flight
// master = core side, slave = responder side.
interface spi_flash_word_reader_if #(
  parameter int ADDR_W = 24
);
  logic              rstrb;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       rdata;
  logic              rbusy;

  modport master (output rstrb, addr, input  rdata, rbusy);
  modport slave  (input  rstrb, addr, output rdata, rbusy);
endinterface

// File: rtl/spi_flash_word_reader.sv
// SPI flash word reader: services 32-bit read strobes by running a READ (0x03)
// transaction in SPI mode 0. Command + 24-bit address go out MSB first, then
// four data bytes come back and are byte-swapped into rdata so the word matches
// little-endian memory order.
// Ports:
//   clk, resetn     system clock, synchronous active-low reset
//   bus (slave)     rstrb / addr in, rdata / rbusy out
//   spi_cs_n        flash chip select, active low
//   spi_clk         SPI clock, idle low
//   spi_mosi        serial data to flash
//   spi_miso        serial data from flash
module spi_flash_word_reader #(
  parameter int CLK_DIV = 1,
  parameter int ADDR_W  = 24
) (
  input  logic                     clk,
  input  logic                     resetn,
  spi_flash_word_reader_if.slave   bus,
  output logic                     spi_cs_n,
  output logic                     spi_clk,
  output logic                     spi_mosi,
  input  logic                     spi_miso
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [0:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [63:0]      shifter;
  logic [63:0]      shifted;
  logic [63:0]      load_word;
  logic [23:0]      addr24;
  logic [31:0]      rdata_q;
  logic             rbusy_q;

  assign bus.rdata = rdata_q;
  assign bus.rbusy = rbusy_q;

  // Word-align by masking; the flash always sees a 24-bit address.
  assign addr24    = 24'(bus.addr);
  assign load_word = {8'h03, addr24 & ~24'h3, 32'h0};

  // Sampled MISO enters at the LSB; it needs 64 shifts to reach bit 63, so
  // MOSI only ever emits the loaded bits (and the data phase stays 0).
  assign shifted   = {shifter[62:0], spi_miso};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
      rdata_q  <= '0;
      rbusy_q  <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.rstrb) begin
            shifter  <= load_word;
            spi_cs_n <= 1'b0;
            rbusy_q  <= 1'b1;
            spi_mosi <= load_word[63];
            spi_clk  <= 1'b0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!spi_clk) begin
              spi_clk <= 1'b1;
            end else begin
              // End of high phase: MISO still holds the flash's bit here.
              spi_clk <= 1'b0;
              shifter <= shifted;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 6'd63) begin
                spi_cs_n <= 1'b1;
                spi_mosi <= 1'b0;
                rbusy_q  <= 1'b0;
                state    <= IDLE;
                // First received byte lands in rdata[7:0].
                rdata_q  <= {shifted[7:0], shifted[15:8], shifted[23:16], shifted[31:24]};
              end else begin
                spi_mosi <= shifted[63];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
